// File: rtl/instr_mem_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them to consecutive
// instruction-memory addresses, one word per accept/write pair.
module instr_mem_loader #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [7:0]        in_opcode,
   input  logic [3:0]        in_rdst,
   input  logic [3:0]        in_rsrc,
   input  logic [7:0]        in_imm,
   input  logic [7:0]        in_disp,
   input  logic [15:0]       in_raw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  words_written
);

   typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  ww_q, ww_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [15:0]       enc_word;

   // Inverse of the instruction-register field split.
   always_comb begin
      enc_word = in_raw;
      unique case (in_fmt)
         2'd0:    enc_word = {in_opcode[7:4], in_rdst, in_opcode[3:0], in_rsrc};
         2'd1:    enc_word = {in_opcode[7:4], in_rdst, in_imm};
         2'd2:    enc_word = {in_opcode[7:4], in_rdst, in_disp};
         default: enc_word = in_raw;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      ww_d        = ww_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = word_count;
               ww_d    = '0;
               state_d = (word_count == '0) ? StDone : StAccept;
            end
         end
         StAccept: begin
            // Memory-side registers only move on accept so they hold between strobes.
            if (in_valid) begin
               mem_addr_d  = addr_q;
               mem_wdata_d = enc_word;
               state_d     = StWrite;
            end
         end
         StWrite: begin
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - CNT_W'(1);
            ww_d    = ww_q + CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? StDone : StAccept;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         rem_q       <= '0;
         ww_q        <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         ww_q        <= ww_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign in_ready      = (state_q == StAccept);
   assign mem_we        = (state_q == StWrite);
   assign busy          = (state_q == StAccept) || (state_q == StWrite);
   assign done          = (state_q == StDone);
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign words_written = ww_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: encoding, sequencing, wrap, ignored starts and
// asynchronous reset in the middle of a session.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_fmt = '0;
   logic [7:0]  in_opcode = '0;
   logic [3:0]  in_rdst = '0;
   logic [3:0]  in_rsrc = '0;
   logic [7:0]  in_imm = '0;
   logic [7:0]  in_disp = '0;
   logic [15:0] in_raw = '0;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic [15:0] words_written;

   int checks = 0;
   int errors = 0;

   instr_mem_loader #(.ADDR_W(16), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_fmt        (in_fmt),
      .in_opcode     (in_opcode),
      .in_rdst       (in_rdst),
      .in_rsrc       (in_rsrc),
      .in_imm        (in_imm),
      .in_disp       (in_disp),
      .in_raw        (in_raw),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .busy          (busy),
      .done          (done),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, "_we"}, 32'(mem_we), 32'h0);
      chk({tag, "_ready"}, 32'(in_ready), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_ww"}, 32'(words_written), 32'h0);
   endtask

   task automatic do_start(input logic [15:0] base, input logic [15:0] cnt);
      base_addr  = base;
      word_count = cnt;
      start      = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called in ACCEPT: presents a bundle, lands in WRITE and checks the strobe.
   task automatic do_word(input string tag, input logic [1:0] fmt, input logic [7:0] op,
                          input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm,
                          input logic [7:0] disp, input logic [15:0] raw,
                          input logic [15:0] exp_addr, input logic [15:0] exp_data);
      chk({tag, "_ready_acc"}, 32'(in_ready), 32'h1);
      in_fmt    = fmt;
      in_opcode = op;
      in_rdst   = rd;
      in_rsrc   = rs;
      in_imm    = imm;
      in_disp   = disp;
      in_raw    = raw;
      in_valid  = 1'b1;
      tick();
      chk({tag, "_we"}, 32'(mem_we), 32'h1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_data));
      chk({tag, "_ready_wr"}, 32'(in_ready), 32'h0);
   endtask

   initial begin
      #2 rst = 1'b1;
      #2 chk_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // Single reg-reg word.
      do_start(16'h0010, 16'd1);
      chk("t1_busy", 32'(busy), 32'h1);
      do_word("t1_w0", 2'd0, 8'h05, 4'd3, 4'd4, 8'h00, 8'h00, 16'h0000, 16'h0010, 16'h0354);
      in_valid = 1'b0;
      tick();
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_busy_done", 32'(busy), 32'h0);
      chk("t1_we_done", 32'(mem_we), 32'h0);
      chk("t1_ww", 32'(words_written), 32'h1);
      tick();
      chk("t1_done_clr", 32'(done), 32'h0);
      chk("t1_ww_hold", 32'(words_written), 32'h1);
      chk("t1_addr_hold", 32'(mem_addr), 32'h0010);
      chk("t1_wdata_hold", 32'(mem_wdata), 32'h0354);

      // Three formats, valid held high throughout.
      do_start(16'h0020, 16'd3);
      chk("t2_ww_clr", 32'(words_written), 32'h0);
      do_word("t2_w0", 2'd1, 8'h50, 4'd2, 4'd9, 8'h7F, 8'h11, 16'h1234, 16'h0020, 16'h527F);
      tick();
      do_word("t2_w1", 2'd2, 8'hC0, 4'd0, 4'd7, 8'h22, 8'hFE, 16'h5678, 16'h0021, 16'hC0FE);
      tick();
      do_word("t2_w2", 2'd3, 8'hFF, 4'd5, 4'd6, 8'h33, 8'h44, 16'hABCD, 16'h0022, 16'hABCD);
      tick();
      in_valid = 1'b0;
      chk("t2_done", 32'(done), 32'h1);
      chk("t2_ww", 32'(words_written), 32'h3);
      tick();

      // Address wrap.
      do_start(16'hFFFF, 16'd2);
      do_word("t3_w0", 2'd3, 8'h00, 4'd0, 4'd0, 8'h00, 8'h00, 16'h1111, 16'hFFFF, 16'h1111);
      tick();
      do_word("t3_w1", 2'd3, 8'h00, 4'd0, 4'd0, 8'h00, 8'h00, 16'h2222, 16'h0000, 16'h2222);
      in_valid = 1'b0;
      tick();
      chk("t3_done", 32'(done), 32'h1);
      chk("t3_ww", 32'(words_written), 32'h2);
      tick();

      // Zero-length session; a start during DONE must be ignored.
      do_start(16'h0500, 16'd0);
      chk("t4_done", 32'(done), 32'h1);
      chk("t4_we", 32'(mem_we), 32'h0);
      chk("t4_busy", 32'(busy), 32'h0);
      chk("t4_ww", 32'(words_written), 32'h0);
      do_start(16'h0600, 16'd1);
      chk("t4_idle_busy", 32'(busy), 32'h0);
      chk("t4_idle_done", 32'(done), 32'h0);
      chk("t4_idle_ready", 32'(in_ready), 32'h0);
      tick();
      chk("t4_still_idle", 32'(busy), 32'h0);

      // Start while busy is ignored; ACCEPT holds while valid is low.
      do_start(16'h0030, 16'd2);
      do_start(16'h0100, 16'd5);
      for (int i = 0; i < 4; i++) begin
         chk("t5_stall_we", 32'(mem_we), 32'h0);
         chk("t5_stall_ready", 32'(in_ready), 32'h1);
         tick();
      end
      do_word("t5_w0", 2'd0, 8'hA1, 4'd1, 4'd2, 8'h00, 8'h00, 16'h0000, 16'h0030, 16'hA112);
      in_valid = 1'b0;
      do_start(16'h0100, 16'd5);
      chk("t5_ready_after", 32'(in_ready), 32'h1);
      do_word("t5_w1", 2'd1, 8'h30, 4'd4, 4'd0, 8'h9C, 8'h00, 16'h0000, 16'h0031, 16'h349C);
      in_valid = 1'b0;
      tick();
      chk("t5_done", 32'(done), 32'h1);
      chk("t5_ww", 32'(words_written), 32'h2);
      tick();

      // Asynchronous reset during the second write of three.
      do_start(16'h0040, 16'd3);
      do_word("t6_w0", 2'd3, 8'h00, 4'd0, 4'd0, 8'h00, 8'h00, 16'hBEEF, 16'h0040, 16'hBEEF);
      tick();
      do_word("t6_w1", 2'd3, 8'h00, 4'd0, 4'd0, 8'h00, 8'h00, 16'hCAFE, 16'h0041, 16'hCAFE);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk_zero("t6_rst");
      tick();
      rst = 1'b0;
      tick();
      chk_zero("t6_post");
      do_start(16'h0060, 16'd1);
      do_word("t6_fresh", 2'd2, 8'h70, 4'd8, 4'd0, 8'h00, 8'h05, 16'h0000, 16'h0060, 16'h7805);
      tick();
      chk("t6_fresh_done", 32'(done), 32'h1);
      chk("t6_fresh_ww", 32'(words_written), 32'h1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
